// File: rtl/sync_model_pkg.sv
// sync_model_pkg: mode constants and FSM state type for the signal-transition engine
package sync_model_pkg;
    localparam int MODE_RR  = 0;
    localparam int MODE_MAX = 1;
    localparam int MODE_EXT = 2;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } fsm_e;
endpackage

// File: rtl/sync_state_engine_rr_pick.sv
// rr_pick: wrapping first-set finder starting at ptr, one-hot plus index result
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                onehot = '0;
                onehot[(int'(ptr) + k) % N] = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/sync_state_engine.sv
// sync_state_engine: steps a gate-level signal model under round-robin, maximal or enabled firing
module sync_state_engine
    import sync_model_pkg::*;
#(
    parameter int               N_SIG = 8,
    parameter int               N_IN  = 2,
    parameter logic [N_SIG-1:0] INIT  = '0,
    parameter int               MODE  = 0,
    parameter int               CNT_W = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_SIG-1:0]                     nxt,
    input  logic [((N_IN > 0) ? N_IN : 1)-1:0]   in_allow,
    input  logic [N_SIG-1:0]                     ext_ena,
    input  logic                                 run,
    input  logic                                 step,
    output logic [N_SIG-1:0]                     state,
    output logic [N_SIG-1:0]                     excited,
    output logic [N_SIG-1:0]                     fired,
    output logic [CNT_W-1:0]                     step_cnt,
    output logic                                 busy,
    output logic                                 deadlock
);
    localparam int PW = $clog2(N_SIG);

    logic [N_SIG-1:0] state_q, state_d, fired_q, fired_d, fire_v;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d, pick_idx;
    fsm_e             fsm_q, fsm_d;
    logic             do_fire;

    for (genvar g = 0; g < N_SIG; g++) begin : g_exc
        if (g < N_IN) begin : g_in
            assign excited[g] = in_allow[g];
        end else begin : g_gate
            assign excited[g] = nxt[g] ^ state_q[g];
        end
    end

    if (MODE == MODE_RR) begin : g_rr
        rr_pick #(.N(N_SIG), .PW(PW)) u_pick (
            .req    (excited),
            .ptr    (ptr_q),
            .onehot (fire_v),
            .idx    (pick_idx)
        );
    end else if (MODE == MODE_MAX) begin : g_max
        assign fire_v   = excited;
        assign pick_idx = '0;
    end else begin : g_ext
        assign fire_v   = excited & ext_ena;
        assign pick_idx = '0;
    end

    always_comb begin
        fsm_d   = fsm_q;
        do_fire = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                fsm_d   = run ? ST_RUN : (step && ~|excited) ? ST_DEAD : ST_IDLE;
                do_fire = !run && step && |fire_v;
            end
            ST_RUN: begin
                fsm_d   = !run ? ST_IDLE : ~|excited ? ST_DEAD : ST_RUN;
                do_fire = run && |fire_v;
            end
            ST_DEAD: fsm_d = |excited ? ST_IDLE : ST_DEAD;
            default: fsm_d = ST_IDLE;
        endcase
        state_d = do_fire ? state_q ^ fire_v : state_q;
        fired_d = do_fire ? fire_v : '0;
        cnt_d   = (do_fire && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
        ptr_d   = (do_fire && MODE == MODE_RR)
                ? ((pick_idx == PW'(N_SIG - 1)) ? '0 : pick_idx + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            fired_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            fsm_q   <= ST_IDLE;
        end else begin
            state_q <= state_d;
            fired_q <= fired_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            fsm_q   <= fsm_d;
        end
    end

    assign state    = state_q;
    assign fired    = fired_q;
    assign step_cnt = cnt_q;
    assign busy     = fsm_q == ST_RUN;
    assign deadlock = fsm_q == ST_DEAD;
endmodule

// File: tb/tb_sync_state_engine.sv
// tb_sync_state_engine: vector table with scoreboard plus reset and saturation sequences
module tb_sync_state_engine;
    typedef struct {
        logic run, step;
        logic [3:0] nxt, ena;
        logic [3:0] rs, rf; logic rb, rd; int rc;
        logic [3:0] ms, mf; logic mb, md; int mc;
        logic [3:0] es, ef; logic eb, ed;
    } vec_t;

    logic clk = 1'b0;
    logic reset, run, step, run_s;
    logic [3:0] nxt, ena;
    logic [3:0] st_rr, fd_rr, ex_rr, st_mx, fd_mx, ex_mx, st_xe, fd_xe, ex_xe, st_in, fd_in, ex_in;
    logic b_rr, d_rr, b_mx, d_mx, b_xe, d_xe, b_in, d_in, b_s, d_s;
    logic [15:0] c_rr, c_mx, c_xe, c_in;
    logic [1:0] st_s, fd_s, ex_s, c_s;
    int checks = 0, errors = 0;
    vec_t tbl [11];
    vec_t sb [$];
    vec_t e;

    always #5 clk = ~clk;

    sync_state_engine #(.N_SIG(4), .N_IN(0), .MODE(0)) u_rr (
        .clk(clk), .reset(reset), .nxt(nxt), .in_allow(1'b0), .ext_ena(ena), .run(run), .step(step),
        .state(st_rr), .excited(ex_rr), .fired(fd_rr), .step_cnt(c_rr), .busy(b_rr), .deadlock(d_rr));
    sync_state_engine #(.N_SIG(4), .N_IN(0), .MODE(1)) u_mx (
        .clk(clk), .reset(reset), .nxt(nxt), .in_allow(1'b0), .ext_ena(ena), .run(run), .step(step),
        .state(st_mx), .excited(ex_mx), .fired(fd_mx), .step_cnt(c_mx), .busy(b_mx), .deadlock(d_mx));
    sync_state_engine #(.N_SIG(4), .N_IN(0), .MODE(2)) u_xe (
        .clk(clk), .reset(reset), .nxt(nxt), .in_allow(1'b0), .ext_ena(ena), .run(run), .step(step),
        .state(st_xe), .excited(ex_xe), .fired(fd_xe), .step_cnt(c_xe), .busy(b_xe), .deadlock(d_xe));
    sync_state_engine #(.N_SIG(4), .N_IN(0), .INIT(4'b1010), .MODE(0)) u_in (
        .clk(clk), .reset(reset), .nxt(nxt), .in_allow(1'b0), .ext_ena(ena), .run(run), .step(step),
        .state(st_in), .excited(ex_in), .fired(fd_in), .step_cnt(c_in), .busy(b_in), .deadlock(d_in));
    sync_state_engine #(.N_SIG(2), .N_IN(1), .MODE(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .nxt(2'b00), .in_allow(1'b1), .ext_ena(2'b00), .run(run_s), .step(1'b0),
        .state(st_s), .excited(ex_s), .fired(fd_s), .step_cnt(c_s), .busy(b_s), .deadlock(d_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_s;
        tbl = '{
            '{1'b1, 1'b0, 4'b1011, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b1011, 4'b0010, 4'b0001, 4'b0001, 1'b1, 1'b0, 1, 4'b1011, 4'b1011, 1'b1, 1'b0, 1, 4'b0010, 4'b0010, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b1011, 4'b0000, 4'b0011, 4'b0010, 1'b1, 1'b0, 2, 4'b1011, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1011, 4'b1000, 1'b1, 1'b0, 3, 4'b1011, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b1, 3, 4'b1011, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'b0011, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b0, 3, 4'b1011, 4'b0000, 1'b0, 1'b0, 1, 4'b0010, 4'b0000, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b1000, 1'b0, 1'b0, 4, 4'b0011, 4'b1000, 1'b0, 1'b0, 2, 4'b0010, 4'b0000, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b1, 4, 4'b0011, 4'b0000, 1'b0, 1'b1, 2, 4'b0010, 4'b0000, 1'b0, 1'b0},
            '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b1, 4, 4'b0011, 4'b0000, 1'b0, 1'b1, 2, 4'b0010, 4'b0000, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b0011, 4'b0001, 4'b0011, 4'b0000, 1'b0, 1'b1, 4, 4'b0011, 4'b0000, 1'b0, 1'b1, 2, 4'b0011, 4'b0001, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b0011, 4'b0001, 4'b0011, 4'b0000, 1'b0, 1'b1, 4, 4'b0011, 4'b0000, 1'b0, 1'b1, 2, 4'b0011, 4'b0000, 1'b0, 1'b1}
        };
        reset = 1'b0; run = 1'b0; step = 1'b0; run_s = 1'b0; nxt = 4'b1011; ena = 4'b0000;
        repeat (2) tick();
        chk("init_state", st_in, 4'b1010);
        chk("init_fired", fd_in, 4'b0000);
        chk("init_cnt", c_in, 0);
        chk("init_busy", b_in, 0);
        chk("init_dead", d_in, 0);
        chk("init_excited", ex_in, 4'b0001);
        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run = tbl[i].run; step = tbl[i].step; nxt = tbl[i].nxt; ena = tbl[i].ena;
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("rr_state[%0d]", i), st_rr, e.rs);
            chk($sformatf("rr_fired[%0d]", i), fd_rr, e.rf);
            chk($sformatf("rr_busy[%0d]", i), b_rr, e.rb);
            chk($sformatf("rr_dead[%0d]", i), d_rr, e.rd);
            chk($sformatf("rr_cnt[%0d]", i), c_rr, e.rc);
            chk($sformatf("mx_state[%0d]", i), st_mx, e.ms);
            chk($sformatf("mx_fired[%0d]", i), fd_mx, e.mf);
            chk($sformatf("mx_busy[%0d]", i), b_mx, e.mb);
            chk($sformatf("mx_dead[%0d]", i), d_mx, e.md);
            chk($sformatf("mx_cnt[%0d]", i), c_mx, e.mc);
            chk($sformatf("xe_state[%0d]", i), st_xe, e.es);
            chk($sformatf("xe_fired[%0d]", i), fd_xe, e.ef);
            chk($sformatf("xe_busy[%0d]", i), b_xe, e.eb);
            chk($sformatf("xe_dead[%0d]", i), d_xe, e.ed);
        end
        // reset in the middle of a run must override the firing and clear ptr
        reset = 1'b0; run = 1'b0; step = 1'b0; nxt = 4'b1011; ena = 4'b0000;
        tick();
        reset = 1'b1; run = 1'b1;
        tick();
        chk("mid_enter_busy", b_rr, 1);
        tick();
        chk("mid_fire0", fd_rr, 4'b0001);
        tick();
        chk("mid_fire1", fd_rr, 4'b0010);
        chk("mid_cnt2", c_rr, 2);
        reset = 1'b0;
        tick();
        chk("mid_rst_state", st_rr, 4'b0000);
        chk("mid_rst_fired", fd_rr, 4'b0000);
        chk("mid_rst_cnt", c_rr, 0);
        chk("mid_rst_busy", b_rr, 0);
        chk("mid_rst_dead", d_rr, 0);
        reset = 1'b1;
        tick();
        chk("mid_reenter_busy", b_rr, 1);
        chk("mid_reenter_fired", fd_rr, 4'b0000);
        tick();
        chk("mid_ptr_zero_fire", fd_rr, 4'b0001);
        // saturating 2-bit counter with an always-permitted input bit
        run = 1'b0; run_s = 1'b1;
        tick();
        chk("sat_busy", b_s, 1);
        chk("sat_state_pre", st_s, 2'b00);
        exp_s = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_s[0] = ~exp_s[0];
            chk($sformatf("sat_state[%0d]", k), st_s, exp_s);
            chk($sformatf("sat_fired[%0d]", k), fd_s, 2'b01);
            chk($sformatf("sat_cnt[%0d]", k), c_s, (k > 3) ? 3 : k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_state_engine.md
SYNC_STATE_ENGINE -- requirements
Module: sync_state_engine

Interface
REQ-001 SHALL have parameter N_SIG, default 8: total modelled signals (inputs plus gate outputs), at least 2.
REQ-002 SHALL have parameter N_IN, default 2: count of environment-input signals, occupying bits [N_IN-1:0]; range 0 to N_SIG.
REQ-003 SHALL have parameter INIT, default all zeros, width N_SIG: initial value of each signal.
REQ-004 SHALL have parameter MODE, default 0: 0 is interleaving round-robin, 1 is maximal-concurrent, 2 is external-enable.
REQ-005 SHALL have parameter CNT_W, default 16: width of the step counter.
REQ-006 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- nxt  in  N_SIG  next-state values from the combinational gate network; bits below N_IN ignored
- in_allow  in  N_IN  environment permits input bit i to toggle
- ext_ena  in  N_SIG  per-signal enable, used only in MODE 2
- run  in  1  level; free-running stepping
- step  in  1  single-step pulse
- state  out  N_SIG  registered signal values
- excited  out  N_SIG  combinational excitation vector
- fired  out  N_SIG  registered; bits toggled in the previous cycle
- step_cnt  out  CNT_W  firing-cycle count
- busy  out  1  FSM in RUN
- deadlock  out  1  FSM in DEAD

Function
REQ-007 SHALL compute excited[i] = in_allow[i] for i < N_IN, and excited[i] = (nxt[i] != state[i]) for i >= N_IN.
REQ-008 SHALL select the fire vector F per mode:
- MODE 0: exactly one bit, the first excited index at or after ptr, searching upward and wrapping.
- MODE 1: F = excited.
- MODE 2: F = excited & ext_ena.
REQ-009 On a firing cycle, SHALL set state <= state ^ F, fired <= F, and step_cnt <= step_cnt + 1, saturating at all ones.
REQ-010 In MODE 0, on a firing cycle, SHALL set ptr to (chosen index + 1) mod N_SIG; ptr SHALL hold otherwise.
REQ-011 On a non-firing cycle, SHALL set fired to 0.
REQ-012 SHALL implement FSM states IDLE, RUN and DEAD.
REQ-013 IDLE behaviour:
- run=1 moves to RUN; no firing that cycle.
- else step=1 with F nonzero fires one step and stays in IDLE.
- else step=1 with excited == 0 moves to DEAD.
REQ-014 RUN behaviour:
- run=0 moves to IDLE without firing.
- else excited == 0 moves to DEAD.
- else fires F (F may be zero in MODE 2, which is a stall and not a deadlock).
REQ-015 DEAD SHALL return to IDLE when excited becomes nonzero; no firing occurs in DEAD.
REQ-016 When run and step are both asserted, run SHALL take priority; step SHALL be ignored while in RUN or DEAD.
REQ-017 Firing latency SHALL be one cycle: F is sampled at edge k, and state and fired update at edge k.
REQ-018 busy SHALL equal (FSM == RUN) and deadlock SHALL equal (FSM == DEAD), both registered-state decodes.

Reset
REQ-019 While reset=0 at a rising edge, SHALL set state=INIT, fired=0, step_cnt=0, ptr=0 and FSM=IDLE; this overrides any concurrent firing.
REQ-020 Reset values SHALL give busy=0 and deadlock=0; excited SHALL reflect INIT against the current nxt and in_allow.

Structure
REQ-021 Shared package sync_model_pkg SHALL hold the MODE constants (MODE_RR, MODE_MAX, MODE_EXT) and the FSM state enum.
REQ-022 SHALL use one sub-module, rr_pick: an N-bit wrapping first-set finder from ptr, returning a one-hot vector and an index.
REQ-023 SHALL elaborate only the selected mode's fire logic through generate.

Verification
REQ-024 N_SIG=4, N_IN=0, INIT=4'b1010, hold reset=0 for 2 cycles -> state=1010, fired=0000, step_cnt=0, busy=0, deadlock=0.
REQ-025 MODE 0, INIT=0, nxt=4'b1011, run=1 -> fired is 0001, 0010, 1000 on successive firing cycles, then state=1011, deadlock=1, step_cnt=3.
REQ-026 MODE 1, same stimulus as REQ-025 -> single firing cycle with fired=1011, then deadlock=1, step_cnt=1.
REQ-027 MODE 2, nxt=4'b1011, ext_ena=0010, run=1 -> only bit 1 fires; then ext_ena=0 with excited=1001 -> no firing, busy=1, deadlock=0.
REQ-028 CNT_W=2, N_IN=1, in_allow=1, MODE 0, run=1 for 5 firing cycles -> step_cnt=3 (saturated), state[0] toggles each firing cycle.
REQ-029 Reset asserted mid-RUN after 2 firings -> next cycle state=INIT, FSM=IDLE, step_cnt=0, ptr=0; with run held, RUN re-entered the following cycle.
